skew_feed_scheduler: RTL



---
 rtl/skew_feed_scheduler.sv | 122 ++++++++++++
 1 files changed

// File: rtl/skew_feed_scheduler.sv
// Diagonal-skew read scheduler feeding ROWS operand FIFOs into the left edge of a systolic array.
// Optional stall-cycle counter output enabled by defining SKEW_STALL_COUNT_EN.
module skew_feed_scheduler #(
  parameter int ROWS      = 4,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [ROWS-1:0]      fifo_empty,
  output logic [ROWS-1:0]      fifo_rd_en,
  output logic [ROWS-1:0]      lane_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 stall
`ifdef SKEW_STALL_COUNT_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);

  // One extra bit beyond len+ROWS so the window compares never wrap.
  localparam int TW = LEN_WIDTH + $clog2(ROWS) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TW-1:0]        t;
  logic [LEN_WIDTH-1:0] len_q;
  logic [TW-1:0]        t_last;
  logic [ROWS-1:0]      active;
  logic                 accept;
  logic                 advance;

  assign accept  = (state == IDLE) && start;
  assign t_last  = TW'(len_q) + TW'(ROWS) - TW'(2);
  assign advance = (state == RUN) && !stall;

  // Row r issues while t is inside its window [r, r+len_q).
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      active[r] = (t >= TW'(r)) && (t < TW'(r) + TW'(len_q));
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt is given a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:   if (!stall && (t == t_last)) state_nxt = FLUSH;
      FLUSH: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; a stall anywhere in the live wavefront freezes every row.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    stall      = 1'b0;
    fifo_rd_en = '0;
    unique case (state)
      RUN: begin
        busy  = 1'b1;
        stall = |(active & fifo_empty);
        if (!stall) fifo_rd_en = active;
      end
      FLUSH: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Tile length and wavefront position; both frozen outside of acceptance/advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t     <= '0;
      len_q <= '0;
    end else if (accept) begin
      t     <= '0;
      len_q <= len;
    end else if (advance) begin
      t     <= t + TW'(1);
    end
  end

  // FIFO data_out is registered, so the lane is valid one cycle after the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lane_valid <= '0;
    else          lane_valid <= fifo_rd_en;
  end

`ifdef SKEW_STALL_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
